// File: rtl/bp_pkg.sv
// Shared encodings for the branch-predictor redirect controller.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_e;

  localparam int unsigned IDX_W_DEFAULT = 8;

endpackage

// File: rtl/bp_sat_ctr.sv
// 2-bit saturating counter next-state: step up on taken, down on not-taken.
module bp_sat_ctr
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    unique case (ctr_i)
      SNT: ctr_o = taken_i ? WNT : SNT;
      WNT: ctr_o = taken_i ? WT  : SNT;
      WT:  ctr_o = taken_i ? ST  : WNT;
      ST:  ctr_o = taken_i ? ST  : WT;
    endcase
  end

endmodule

// File: rtl/bp_redirect_ctrl.sv
// Next-PC selection, mispredict flush and predictor-table write port, with a
// table-clearing init sweep after reset or ClearReq.
module bp_redirect_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEFAULT,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ClearReq,
  input  logic [31:0]      PCF,
  input  logic             PredTakenF,
  input  logic [31:0]      PredTargetF,
  input  logic             BranchE,
  input  logic             JumpE,
  input  logic             PCSrcE,
  input  logic             PredTakenE,
  input  logic [31:0]      PredTargetE,
  input  logic [1:0]       CtrE,
  input  logic [31:0]      PCE,
  input  logic [31:0]      PCTargetE,
  output logic [31:0]      PCNextF,
  output logic             FlushD,
  output logic             FlushE,
  output logic             StallReqF,
  output logic             UpdEn,
  output logic [IDX_W-1:0] UpdIdx,
  output logic [1:0]       UpdCtr,
  output logic [31:0]      UpdTarget,
  output logic [CNT_W-1:0] MispredCnt
);

  bp_state_e        state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic             pend_vld_q, pend_vld_d;
  logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
  logic [1:0]       pend_ctr_q, pend_ctr_d;
  logic [31:0]      pend_tgt_q, pend_tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run;
  logic             mis;
  logic [1:0]       ctr_next;

  bp_sat_ctr u_sat_ctr (
    .ctr_i   (CtrE),
    .taken_i (PCSrcE),
    .ctr_o   (ctr_next)
  );

  assign run = (state_q == ST_RUN);
  assign mis = run & ((BranchE & (PCSrcE != PredTakenE)) |
                      ((BranchE | JumpE) & PCSrcE & PredTakenE & (PCTargetE != PredTargetE)) |
                      (JumpE & ~PredTakenE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      sweep_q    <= '0;
      pend_vld_q <= 1'b0;
      pend_idx_q <= '0;
      pend_ctr_q <= SNT;
      pend_tgt_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      pend_vld_q <= pend_vld_d;
      pend_idx_q <= pend_idx_d;
      pend_ctr_q <= pend_ctr_d;
      pend_tgt_q <= pend_tgt_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    pend_vld_d = 1'b0;
    pend_idx_d = pend_idx_q;
    pend_ctr_d = pend_ctr_q;
    pend_tgt_d = pend_tgt_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        sweep_d = sweep_q + IDX_W'(1);
        if (sweep_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ClearReq) begin
          state_d = ST_INIT;
          sweep_d = '0;
          cnt_d   = '0;
        end else begin
          if (mis && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
          if (BranchE) begin
            pend_vld_d = 1'b1;
            pend_idx_d = PCE[IDX_W+1:2];
            pend_ctr_d = ctr_next;
            pend_tgt_d = PCSrcE ? PCTargetE : PredTargetE;
          end
        end
      end
    endcase
  end

  always_comb begin
    FlushD     = mis;
    FlushE     = mis;
    StallReqF  = ~run;
    MispredCnt = cnt_q;
    if (!run)              PCNextF = PCF;
    else if (mis)          PCNextF = PCSrcE ? PCTargetE : (PCE + 32'd4);
    else if (PredTakenF)   PCNextF = PredTargetF;
    else                   PCNextF = PCF + 32'd4;
    if (!run) begin
      UpdEn     = 1'b1;
      UpdIdx    = sweep_q;
      UpdCtr    = WNT;
      UpdTarget = '0;
    end else begin
      // A clear arriving alongside a queued write cancels that write.
      UpdEn     = pend_vld_q & ~ClearReq;
      UpdIdx    = pend_idx_q;
      UpdCtr    = pend_ctr_q;
      UpdTarget = pend_tgt_q;
    end
  end

endmodule

// File: tb/tb_bp_redirect_ctrl.sv
// Self-checking bench for bp_redirect_ctrl: directed scenarios plus random traffic
// against a behavioural model of the redirect/update rules.
module tb_bp_redirect_ctrl;

  localparam int unsigned IDX_W = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned TBL   = 1 << IDX_W;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ClearReq, PredTakenF, BranchE, JumpE, PCSrcE, PredTakenE;
  logic [31:0] PCF, PredTargetF, PredTargetE, PCE, PCTargetE;
  logic [1:0] CtrE;
  logic [31:0] PCNextF, UpdTarget;
  logic FlushD, FlushE, StallReqF, UpdEn;
  logic [IDX_W-1:0] UpdIdx;
  logic [1:0] UpdCtr;
  logic [CNT_W-1:0] MispredCnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bp_redirect_ctrl #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ClearReq(ClearReq), .PCF(PCF), .PredTakenF(PredTakenF),
    .PredTargetF(PredTargetF), .BranchE(BranchE), .JumpE(JumpE), .PCSrcE(PCSrcE),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .CtrE(CtrE), .PCE(PCE),
    .PCTargetE(PCTargetE), .PCNextF(PCNextF), .FlushD(FlushD), .FlushE(FlushE),
    .StallReqF(StallReqF), .UpdEn(UpdEn), .UpdIdx(UpdIdx), .UpdCtr(UpdCtr),
    .UpdTarget(UpdTarget), .MispredCnt(MispredCnt)
  );

  // Behavioural model state
  bit m_run;
  int unsigned m_sweep, m_cnt, m_pidx, m_pctr;
  bit m_pv;
  logic [31:0] m_ptgt;
  // Expected combinational outputs for the current inputs
  bit e_mis, e_upden;
  logic [31:0] e_pcnext, e_tgt;
  int unsigned e_idx, e_ctr;

  function automatic int unsigned sat2(int unsigned c, bit taken);
    if (taken) return (c == 3) ? 3 : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  task automatic model_reset();
    m_run = 0; m_sweep = 0; m_cnt = 0; m_pv = 0; m_pidx = 0; m_pctr = 0; m_ptgt = '0;
  endtask

  task automatic model_eval();
    bit wrong_dir, wrong_tgt, blind_jump;
    wrong_dir  = BranchE && (PCSrcE != PredTakenE);
    wrong_tgt  = (BranchE || JumpE) && PCSrcE && PredTakenE && (PCTargetE != PredTargetE);
    blind_jump = JumpE && !PredTakenE;
    e_mis = m_run && (wrong_dir || wrong_tgt || blind_jump);
    if (!m_run)          e_pcnext = PCF;
    else if (e_mis)      e_pcnext = PCSrcE ? PCTargetE : PCE + 32'd4;
    else if (PredTakenF) e_pcnext = PredTargetF;
    else                 e_pcnext = PCF + 32'd4;
    if (!m_run) begin
      e_upden = 1; e_idx = m_sweep; e_ctr = 1; e_tgt = '0;
    end else begin
      e_upden = m_pv && !ClearReq; e_idx = m_pidx; e_ctr = m_pctr; e_tgt = m_ptgt;
    end
  endtask

  task automatic model_clock();
    model_eval();
    if (!m_run) begin
      m_sweep++;
      if (m_sweep == TBL) begin m_run = 1; m_sweep = 0; end
    end else if (ClearReq) begin
      m_run = 0; m_sweep = 0; m_pv = 0; m_cnt = 0;
    end else begin
      if (e_mis && m_cnt < CMAX) m_cnt++;
      m_pv = BranchE;
      if (BranchE) begin
        m_pidx = (PCE >> 2) % TBL;
        m_pctr = sat2(int'(CtrE), PCSrcE);
        m_ptgt = PCSrcE ? PCTargetE : PredTargetE;
      end
    end
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ClearReq = 0; PredTakenF = 0; BranchE = 0; JumpE = 0; PCSrcE = 0; PredTakenE = 0;
    PCF = 32'h1000; PredTargetF = 0; PredTargetE = 0; PCE = 0; PCTargetE = 0; CtrE = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1;
    #1 rst_n = 0;
    #12;
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    #3;
    checks++;
    if ({UpdEn, StallReqF, FlushD, FlushE} !== 4'b1100) begin
      errors++; $display("FAIL reset_flags: got %b want 1100", {UpdEn, StallReqF, FlushD, FlushE});
    end
    checks++;
    if (MispredCnt !== '0 || UpdIdx !== '0) begin
      errors++; $display("FAIL reset_regs: got cnt=%h idx=%h want 0/0", MispredCnt, UpdIdx);
    end
  endtask

  // Expects to be entered in the first cycle of a sweep (index 0).
  task automatic test_sweep();
    for (int i = 0; i < int'(TBL); i++) begin
      #3;
      checks++;
      if ({UpdEn, UpdIdx, UpdCtr, UpdTarget, StallReqF} !== {1'b1, i[7:0], 2'b01, 32'h0, 1'b1})
      begin
        errors++;
        $display("FAIL sweep[%0d]: got en=%b idx=%h ctr=%b tgt=%h stall=%b want 1/%h/01/0/1",
                 i, UpdEn, UpdIdx, UpdCtr, UpdTarget, StallReqF, i[7:0]);
      end
      if (i == 5) begin
        checks++;
        if (PCNextF !== PCF) begin
          errors++; $display("FAIL sweep_pc_hold: got %h want %h", PCNextF, PCF);
        end
      end
      tick();
    end
    #3;
    checks++;
    if (StallReqF !== 1'b0) begin
      errors++; $display("FAIL sweep_end_stall: got %b want 0", StallReqF);
    end
    tick();
  endtask

  task automatic test_correct_pred();
    idle();
    BranchE = 1; PCSrcE = 1; PredTakenE = 1; PCTargetE = 32'h100; PredTargetE = 32'h100;
    CtrE = 2'b10; PCE = 32'h40;
    #3;
    checks++;
    if ({FlushD, FlushE} !== 2'b00 || PCNextF !== 32'h1004) begin
      errors++; $display("FAIL correct_flush: got fl=%b pc=%h want 00/1004", {FlushD, FlushE}, PCNextF);
    end
    tick();
    idle();
    #3;
    checks++;
    if ({UpdEn, UpdIdx, UpdCtr, UpdTarget} !== {1'b1, 8'h10, 2'b11, 32'h100}) begin
      errors++; $display("FAIL correct_upd: got en=%b idx=%h ctr=%b tgt=%h want 1/10/11/100",
                         UpdEn, UpdIdx, UpdCtr, UpdTarget);
    end
    checks++;
    if (MispredCnt !== 16'd0) begin
      errors++; $display("FAIL correct_cnt: got %h want 0", MispredCnt);
    end
    tick();
    #3;
    checks++;
    if (UpdEn !== 1'b0) begin
      errors++; $display("FAIL upd_pulse: got %b want 0", UpdEn);
    end
    tick();
  endtask

  task automatic test_taken_mispred();
    idle();
    BranchE = 1; PCSrcE = 1; PredTakenE = 0; PCTargetE = 32'h200; CtrE = 2'b00; PCE = 32'h44;
    #3;
    checks++;
    if (PCNextF !== 32'h200 || {FlushD, FlushE} !== 2'b11) begin
      errors++; $display("FAIL taken_mis: got pc=%h fl=%b want 200/11", PCNextF, {FlushD, FlushE});
    end
    tick();
    idle();
    #3;
    checks++;
    if ({MispredCnt, UpdCtr, UpdIdx, UpdTarget} !== {16'd1, 2'b01, 8'h11, 32'h200}) begin
      errors++; $display("FAIL taken_mis_upd: got cnt=%h ctr=%b idx=%h tgt=%h want 1/01/11/200",
                         MispredCnt, UpdCtr, UpdIdx, UpdTarget);
    end
    tick();
  endtask

  task automatic test_ntaken_mispred();
    idle();
    BranchE = 1; PCSrcE = 0; PredTakenE = 1; PCE = 32'h80; PredTakenF = 1;
    PredTargetF = 32'h3000; CtrE = 2'b10; PredTargetE = 32'h500; PCTargetE = 32'h500;
    #3;
    checks++;
    if (PCNextF !== 32'h84 || {FlushD, FlushE} !== 2'b11) begin
      errors++; $display("FAIL ntaken_mis: got pc=%h fl=%b want 84/11", PCNextF, {FlushD, FlushE});
    end
    tick();
    idle();
    #3;
    checks++;
    if ({UpdCtr, UpdIdx, UpdTarget, MispredCnt} !== {2'b01, 8'h20, 32'h500, 16'd2}) begin
      errors++; $display("FAIL ntaken_upd: got ctr=%b idx=%h tgt=%h cnt=%h want 01/20/500/2",
                         UpdCtr, UpdIdx, UpdTarget, MispredCnt);
    end
    tick();
  endtask

  task automatic test_jump();
    idle();
    JumpE = 1; PCSrcE = 1; PredTakenE = 0; PCTargetE = 32'h7000; PCE = 32'h90;
    #3;
    checks++;
    if (PCNextF !== 32'h7000 || FlushE !== 1'b1) begin
      errors++; $display("FAIL jump_blind: got pc=%h fl=%b want 7000/1", PCNextF, FlushE);
    end
    tick();
    idle();
    JumpE = 1; PCSrcE = 1; PredTakenE = 1; PCTargetE = 32'h7000; PredTargetE = 32'h7000;
    #3;
    checks++;
    if (UpdEn !== 1'b0 || FlushD !== 1'b0 || PCNextF !== 32'h1004) begin
      errors++; $display("FAIL jump_ok: got en=%b fl=%b pc=%h want 0/0/1004", UpdEn, FlushD, PCNextF);
    end
    PredTargetE = 32'h7400;
    #1;
    checks++;
    if (PCNextF !== 32'h7000 || FlushD !== 1'b1) begin
      errors++; $display("FAIL jump_tgt: got pc=%h fl=%b want 7000/1", PCNextF, FlushD);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_wrap();
    idle();
    BranchE = 1; PCSrcE = 0; PredTakenE = 1; PCE = 32'hFFFF_FFFC; CtrE = 2'b01;
    #3;
    checks++;
    if (PCNextF !== 32'h0) begin
      errors++; $display("FAIL wrap_pce: got %h want 0", PCNextF);
    end
    tick();
    idle();
    PCF = 32'hFFFF_FFFC;
    #3;
    checks++;
    if (PCNextF !== 32'h0 || UpdIdx !== 8'hFF || UpdCtr !== 2'b00) begin
      errors++; $display("FAIL wrap_pcf: got pc=%h idx=%h ctr=%b want 0/ff/00", PCNextF, UpdIdx, UpdCtr);
    end
    tick();
  endtask

  task automatic test_saturation();
    idle();
    BranchE = 1; PCSrcE = 1; PredTakenE = 1; PCTargetE = 32'h600; PredTargetE = 32'h600;
    CtrE = 2'b11;
    tick();
    idle();
    BranchE = 1; PCSrcE = 0; PredTakenE = 0; CtrE = 2'b00;
    #3;
    checks++;
    if (UpdCtr !== 2'b11) begin
      errors++; $display("FAIL sat_hi: got %b want 11", UpdCtr);
    end
    tick();
    idle();
    #3;
    checks++;
    if (UpdCtr !== 2'b00) begin
      errors++; $display("FAIL sat_lo: got %b want 00", UpdCtr);
    end
    JumpE = 1; PredTakenE = 0; PCSrcE = 1; PCTargetE = 32'h800;
    for (int n = 0; n < 70000 && m_cnt < CMAX; n++) tick();
    #3;
    checks++;
    if (MispredCnt !== 16'hFFFF) begin
      errors++; $display("FAIL cnt_reach: got %h want ffff", MispredCnt);
    end
    for (int n = 0; n < 3; n++) tick();
    #3;
    checks++;
    if (MispredCnt !== 16'hFFFF) begin
      errors++; $display("FAIL cnt_sat: got %h want ffff", MispredCnt);
    end
    idle();
    tick();
  endtask

  task automatic test_clear();
    idle();
    BranchE = 1; PCSrcE = 1; PredTakenE = 1; PCTargetE = 32'h100; PredTargetE = 32'h100;
    PCE = 32'h40; CtrE = 2'b01;
    tick();
    idle();
    ClearReq = 1;
    #3;
    checks++;
    if (UpdEn !== 1'b0) begin
      errors++; $display("FAIL clear_drop: got %b want 0", UpdEn);
    end
    tick();
    idle();
    #3;
    checks++;
    if ({StallReqF, UpdEn, UpdIdx, MispredCnt} !== {1'b1, 1'b1, 8'h00, 16'h0}) begin
      errors++; $display("FAIL clear_restart: got st=%b en=%b idx=%h cnt=%h want 1/1/00/0000",
                         StallReqF, UpdEn, UpdIdx, MispredCnt);
    end
    ClearReq = 1;  // ignored while sweeping
    for (int i = 0; i < 37; i++) tick();
    ClearReq = 0;
    #3;
    checks++;
    if (UpdIdx !== 8'd37) begin
      errors++; $display("FAIL clear_sweep37: got %h want 25", UpdIdx);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({UpdIdx, UpdEn, StallReqF, MispredCnt} !== {8'h00, 1'b1, 1'b1, 16'h0}) begin
      errors++; $display("FAIL async_rst: got idx=%h en=%b st=%b cnt=%h want 00/1/1/0000",
                         UpdIdx, UpdEn, StallReqF, MispredCnt);
    end
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    test_sweep();
  endtask

  task automatic test_random();
    int unsigned kind;
    for (int c = 0; c < 3000; c++) begin
      kind = $urandom_range(0, 3);
      ClearReq    = ($urandom_range(0, 299) == 0);
      BranchE     = (kind == 1);
      JumpE       = (kind == 2);
      PCSrcE      = $urandom_range(0, 1);
      PredTakenE  = $urandom_range(0, 1);
      PredTakenF  = $urandom_range(0, 1);
      CtrE        = 2'($urandom_range(0, 3));
      PCF         = $urandom & 32'hFFFF_FFFC;
      PCE         = $urandom & 32'hFFFF_FFFC;
      PredTargetF = $urandom & 32'hFFFF_FFFC;
      PredTargetE = $urandom & 32'hFFFF_FFFC;
      PCTargetE   = $urandom_range(0, 1) ? PredTargetE : ($urandom & 32'hFFFF_FFFC);
      #3;
      model_eval();
      checks++;
      if (PCNextF !== e_pcnext || FlushD !== e_mis || FlushE !== e_mis ||
          StallReqF !== !m_run || UpdEn !== e_upden || MispredCnt !== CNT_W'(m_cnt)) begin
        errors++;
        $display("FAIL rand[%0d]: got pc=%h fl=%b%b st=%b en=%b cnt=%h want %h/%b/%b/%b/%h",
                 c, PCNextF, FlushD, FlushE, StallReqF, UpdEn, MispredCnt,
                 e_pcnext, e_mis, !m_run, e_upden, CNT_W'(m_cnt));
      end
      if (e_upden) begin
        checks++;
        if (UpdIdx !== IDX_W'(e_idx) || UpdCtr !== 2'(e_ctr) || UpdTarget !== e_tgt) begin
          errors++;
          $display("FAIL rand_upd[%0d]: got idx=%h ctr=%b tgt=%h want %h/%b/%h",
                   c, UpdIdx, UpdCtr, UpdTarget, IDX_W'(e_idx), 2'(e_ctr), e_tgt);
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_correct_pred();
    test_taken_mispred();
    test_ntaken_mispred();
    test_jump();
    test_wrap();
    test_saturation();
    test_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
